multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Sequencing controller for the multicycle RV32I core.
- It decodes the instruction held in the instruction register and drives the shared ALU, register file, instruction register and unified memory port through a Moore FSM, one state per cycle.
- Memory accesses use a request/ready handshake with a bounded wait timeout.
- It sits between the datapath and the testbench interface and exposes its FSM state for observation.

Parameters:
- RegBits, 32: width of the instr input.
- MaxWait, 255: maximum cycles spent waiting for mem_ready before a bus error is raised.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- instr  input  RegBits  instruction register contents; fields opcode[6:0], funct3[14:12], funct7b5[30].
- onzc  input  4  ALU flags from the current cycle: [3] overflow, [2] negative, [1] zero, [0] carry (carry=1 means no borrow on subtract).
- mem_ready  input  1  memory has completed the current access.
- mem_request  output  1  memory access in progress.
- adr_source  output  1  0 = memory address from pc, 1 = from alu_out register.
- ir_write  output  1  load instr and old_pc.
- pc_write  output  1  load pc from result.
- memory_write  output  1  store strobe.
- reg_write  output  1  register file write enable.
- alu_source_a  output  2  00 pc, 01 old_pc, 10 register_a, 11 zero.
- alu_source_b  output  2  00 register_b, 01 immediate_extended, 10 constant 4.
- alu_control  output  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
- result_source  output  2  00 alu_out register, 01 data register, 10 alu_result.
- immediate_source  output  3  0 I, 1 S, 2 B, 3 J, 4 U.
- illegal  output  1  sticky: unsupported opcode.
- bus_error  output  1  sticky: memory wait timeout.
- state  output  4  current FSM state encoding, for debug.

Behaviour:
- Reset:
  - rst high at a clock edge puts the FSM in FETCH, clears the wait counter, illegal and bus_error.
  - While rst is high, every strobe (mem_request, ir_write, pc_write, memory_write, reg_write) is forced to 0 and all selects read 0.
  - Reset mid-instruction abandons the instruction; no strobe fires in that cycle.
- States: 0 FETCH, 1 DECODE, 2 MEM_ADR, 3 MEM_READ, 4 MEM_WB, 5 MEM_WRITE, 6 EXEC_R, 7 EXEC_I, 8 ALU_WB, 9 BRANCH, 10 JAL, 11 JALR, 12 JALR_LINK, 13 LUI, 14 TRAP.
- FETCH:
  - Drives mem_request=1, adr_source=0, ALU computes pc+4 (a=00, b=10, ADD), result_source=10.
  - ir_write and pc_write assert only in the cycle mem_ready=1, then go to DECODE; otherwise stay in FETCH.
- DECODE:
  - ALU computes old_pc+imm (a=01, b=01, ADD, immediate_source=B) into alu_out.
  - Next state by opcode:
    - 0000011 load → MEM_ADR
    - 0100011 store → MEM_ADR
    - 0110011 R-type → EXEC_R
    - 0010011 I-ALU → EXEC_I
    - 1100011 branch → BRANCH
    - 1101111 jal → JAL
    - 1100111 jalr → JALR
    - 0110111 lui → LUI
    - anything else → TRAP with illegal=1
- MEM_ADR: a=10, b=01, ADD; immediate_source is S for stores, I for loads. Next state MEM_WRITE for stores, MEM_READ for loads.
- MEM_READ: mem_request=1, adr_source=1; waits for mem_ready, then MEM_WB.
- MEM_WB: result_source=01, reg_write=1, then FETCH.
- MEM_WRITE: mem_request=1, adr_source=1, memory_write=1 held until mem_ready, then FETCH.
- EXEC_R / EXEC_I:
  - a=10, b=00 (R) or b=01 with imm I (I); then ALU_WB.
  - alu_control from funct3:
    - 000: ADD, or SUB if R-type and funct7b5=1
    - 001: SLL
    - 010: SLT
    - 011: SLTU
    - 100: XOR
    - 101: SRA if funct7b5=1, else SRL
    - 110: OR
    - 111: AND
  - funct7b5 is ignored for I-type funct3=000.
- ALU_WB: result_source=00, reg_write=1, then FETCH.
- BRANCH:
  - a=10, b=00, SUB, result_source=00; pc_write is combinational from onzc in this cycle.
  - Conditions by funct3: 000 z, 001 !z, 100 n^o, 101 !(n^o), 110 !c, 111 c.
  - funct3 010/011 → TRAP with illegal=1, no pc_write. Otherwise next state FETCH.
- JAL: a=01, b=10, ADD; result_source=00, pc_write=1; then ALU_WB, which writes old_pc+4 latched into alu_out.
- JALR: a=10, b=01, imm I, ADD; then JALR_LINK.
- JALR_LINK: a=01, b=10, ADD, result_source=00, pc_write=1; then ALU_WB. rs1 is read before rd is written, so rd==rs1 is safe.
- LUI: a=11, b=01, imm U, ADD; then ALU_WB.
- Wait counter:
  - Counts consecutive cycles in FETCH, MEM_READ or MEM_WRITE with mem_ready=0, and clears on every state change.
  - When it reaches MaxWait with mem_ready still 0, the next state is TRAP and bus_error=1.
  - A mem_ready=1 arriving on that same cycle wins: the access completes normally.
- TRAP: all strobes 0; the FSM stays in TRAP until rst.

Test Plan:
- mem_ready tied 1, instr=0x002081B3 (add x3,x1,x2) → states FETCH, DECODE, EXEC_R, ALU_WB; reg_write=1 only in cycle 4 with alu_control=0; back to FETCH in cycle 5.
- lw x5,8(x1) with mem_ready delayed 3 cycles in MEM_READ → MEM_READ held 4 cycles with mem_request=1, then MEM_WB with result_source=01, reg_write=1; 8 cycles total including FETCH.
- beq with onzc=4'b0010 → pc_write=1 in BRANCH; same instr with onzc=4'b0000 → pc_write=0. blt with onzc=4'b1000 → pc_write=1 (n^o=1).
- jalr x1,0(x1) with mem_ready=1 → FETCH, DECODE, JALR, JALR_LINK (pc_write=1), ALU_WB (reg_write=1): 5 cycles.
- opcode 0x7F → TRAP, illegal=1, no strobes for 10 cycles; rst for one cycle → FETCH, illegal=0.
- MaxWait=4, mem_ready=0 in FETCH → TRAP after 4 wait cycles with bus_error=1; rst asserted during a MEM_WRITE wait → memory_write=0 that cycle, FETCH next.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Unified memory port handshake between the control unit and memory.
// The controller raises mem_request; memory answers with mem_ready.
interface multicycle_control_unit_if;
  logic mem_request;
  logic mem_ready;
  logic memory_write;
  logic adr_source;

  modport master (
    output mem_request,
    output memory_write,
    output adr_source,
    input  mem_ready
  );

  modport slave (
    input  mem_request,
    input  memory_write,
    input  adr_source,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing the multicycle RV32I datapath.
// Memory waits are bounded; illegal opcodes and timeouts park in TRAP.
module multicycle_control_unit #(
  parameter int RegBits = 32,
  parameter int MaxWait = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegBits-1:0]    instr,
  input  logic [3:0]            onzc,
  multicycle_control_unit_if.master mem,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            alu_source_a,
  output logic [1:0]            alu_source_b,
  output logic [3:0]            alu_control,
  output logic [1:0]            result_source,
  output logic [2:0]            immediate_source,
  output logic                  illegal,
  output logic                  bus_error,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9,
    JAL       = 4'd10,
    JALR      = 4'd11,
    JALR_LINK = 4'd12,
    LUI       = 4'd13,
    TRAP      = 4'd14
  } state_t;

  localparam logic [3:0] ADD  = 4'd0;
  localparam logic [3:0] SUB  = 4'd1;
  localparam logic [3:0] AND  = 4'd2;
  localparam logic [3:0] OR   = 4'd3;
  localparam logic [3:0] XOR  = 4'd4;
  localparam logic [3:0] SLL  = 4'd5;
  localparam logic [3:0] SRL  = 4'd6;
  localparam logic [3:0] SRA  = 4'd7;
  localparam logic [3:0] SLT  = 4'd8;
  localparam logic [3:0] SLTU = 4'd9;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  localparam int CntW = $clog2(MaxWait + 1);

  state_t cur, nxt;
  logic [CntW-1:0] cnt;
  logic [6:0] op;
  logic [2:0] f3;
  logic f7;
  logic wait_st, timeout;
  logic set_ill, set_berr;
  logic req, adr, mwr;
  logic [3:0] alu_dec;
  logic unused_bits;

  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign f7 = instr[30];
  assign unused_bits = ^{instr[RegBits-1:31], instr[29:15], instr[11:7]};

  assign wait_st = (cur == FETCH) || (cur == MEM_READ) ||
                   (cur == MEM_WRITE);
  assign timeout = wait_st && !mem.mem_ready &&
                   (cnt == CntW'(MaxWait - 1));

  assign mem.mem_request  = req;
  assign mem.adr_source   = adr;
  assign mem.memory_write = mwr;
  assign state = cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur       <= FETCH;
      cnt       <= '0;
      illegal   <= 1'b0;
      bus_error <= 1'b0;
    end else begin
      cur <= nxt;
      if (wait_st && !mem.mem_ready && nxt == cur)
        cnt <= cnt + CntW'(1);
      else
        cnt <= '0;
      if (set_ill)  illegal   <= 1'b1;
      if (set_berr) bus_error <= 1'b1;
    end
  end

  // funct7b5 only selects SUB for register-register ops
  always_comb begin
    alu_dec = ADD;
    unique case (f3)
      3'b000: alu_dec = (cur == EXEC_R && f7) ? SUB : ADD;
      3'b001: alu_dec = SLL;
      3'b010: alu_dec = SLT;
      3'b011: alu_dec = SLTU;
      3'b100: alu_dec = XOR;
      3'b101: alu_dec = f7 ? SRA : SRL;
      3'b110: alu_dec = OR;
      3'b111: alu_dec = AND;
    endcase
  end

  always_comb begin
    nxt              = cur;
    req              = 1'b0;
    adr              = 1'b0;
    mwr              = 1'b0;
    ir_write         = 1'b0;
    pc_write         = 1'b0;
    reg_write        = 1'b0;
    alu_source_a     = 2'b00;
    alu_source_b     = 2'b00;
    alu_control      = ADD;
    result_source    = 2'b00;
    immediate_source = 3'd0;
    set_ill          = 1'b0;
    set_berr         = 1'b0;
    unique case (cur)
      FETCH: begin
        req           = 1'b1;
        alu_source_b  = 2'b10;
        result_source = 2'b10;
        if (mem.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nxt      = DECODE;
        end else if (timeout) begin
          nxt      = TRAP;
          set_berr = 1'b1;
        end
      end
      DECODE: begin
        alu_source_a     = 2'b01;
        alu_source_b     = 2'b01;
        immediate_source = 3'd2;
        unique case (op)
          OP_LOAD, OP_STORE: nxt = MEM_ADR;
          OP_R:    nxt = EXEC_R;
          OP_I:    nxt = EXEC_I;
          OP_BR:   nxt = BRANCH;
          OP_JAL:  nxt = JAL;
          OP_JALR: nxt = JALR;
          OP_LUI:  nxt = LUI;
          default: begin
            nxt     = TRAP;
            set_ill = 1'b1;
          end
        endcase
      end
      MEM_ADR: begin
        alu_source_a = 2'b10;
        alu_source_b = 2'b01;
        if (op == OP_STORE) begin
          immediate_source = 3'd1;
          nxt = MEM_WRITE;
        end else begin
          nxt = MEM_READ;
        end
      end
      MEM_READ: begin
        req = 1'b1;
        adr = 1'b1;
        if (mem.mem_ready) nxt = MEM_WB;
        else if (timeout) begin
          nxt      = TRAP;
          set_berr = 1'b1;
        end
      end
      MEM_WB: begin
        result_source = 2'b01;
        reg_write     = 1'b1;
        nxt           = FETCH;
      end
      MEM_WRITE: begin
        req = 1'b1;
        adr = 1'b1;
        mwr = 1'b1;
        if (mem.mem_ready) nxt = FETCH;
        else if (timeout) begin
          nxt      = TRAP;
          set_berr = 1'b1;
        end
      end
      EXEC_R: begin
        alu_source_a = 2'b10;
        alu_control  = alu_dec;
        nxt          = ALU_WB;
      end
      EXEC_I: begin
        alu_source_a = 2'b10;
        alu_source_b = 2'b01;
        alu_control  = alu_dec;
        nxt          = ALU_WB;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        nxt       = FETCH;
      end
      BRANCH: begin
        alu_source_a = 2'b10;
        alu_control  = SUB;
        nxt          = FETCH;
        unique case (f3)
          3'b000: pc_write = onzc[1];
          3'b001: pc_write = !onzc[1];
          3'b100: pc_write = onzc[2] ^ onzc[3];
          3'b101: pc_write = !(onzc[2] ^ onzc[3]);
          3'b110: pc_write = !onzc[0];
          3'b111: pc_write = onzc[0];
          default: begin
            nxt     = TRAP;
            set_ill = 1'b1;
          end
        endcase
      end
      JAL: begin
        alu_source_a = 2'b01;
        alu_source_b = 2'b10;
        pc_write     = 1'b1;
        nxt          = ALU_WB;
      end
      JALR: begin
        alu_source_a = 2'b10;
        alu_source_b = 2'b01;
        nxt          = JALR_LINK;
      end
      JALR_LINK: begin
        alu_source_a = 2'b01;
        alu_source_b = 2'b10;
        pc_write     = 1'b1;
        nxt          = ALU_WB;
      end
      LUI: begin
        alu_source_a     = 2'b11;
        alu_source_b     = 2'b01;
        immediate_source = 3'd4;
        nxt              = ALU_WB;
      end
      TRAP: nxt = TRAP;
      default: nxt = TRAP;
    endcase
    // reset silences every strobe and select in its own cycle
    if (rst) begin
      req              = 1'b0;
      adr              = 1'b0;
      mwr              = 1'b0;
      ir_write         = 1'b0;
      pc_write         = 1'b0;
      reg_write        = 1'b0;
      alu_source_a     = 2'b00;
      alu_source_b     = 2'b00;
      alu_control      = ADD;
      result_source    = 2'b00;
      immediate_source = 3'd0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: instruction-level model queues per-cycle expectations,
// a negedge monitor compares them against the control outputs.
module tb_multicycle_control_unit;
  localparam int MW = 4;

  localparam logic [3:0] S_FETCH = 0, S_DECODE = 1, S_MEM_ADR = 2;
  localparam logic [3:0] S_MEM_READ = 3, S_MEM_WB = 4, S_MEM_WRITE = 5;
  localparam logic [3:0] S_EXEC_R = 6, S_EXEC_I = 7, S_ALU_WB = 8;
  localparam logic [3:0] S_BRANCH = 9, S_JAL = 10, S_JALR = 11;
  localparam logic [3:0] S_JALR_LINK = 12, S_LUI = 13, S_TRAP = 14;

  typedef struct packed {
    logic [3:0] st;
    logic mreq, adr, irw, pcw, mw, rw;
    logic [1:0] sa, sb;
    logic [3:0] alu;
    logic [1:0] rs;
    logic [2:0] imm;
    logic ill, berr;
  } exp_t;

  logic clk = 0;
  logic rst = 1;
  logic [31:0] instr = 0;
  logic [3:0] onzc = 0;
  logic ir_write, pc_write, reg_write, illegal, bus_error;
  logic [1:0] alu_source_a, alu_source_b, result_source;
  logic [3:0] alu_control, dstate;
  logic [2:0] immediate_source;

  multicycle_control_unit_if bus();

  multicycle_control_unit #(.RegBits(32), .MaxWait(MW)) dut (
    .clk(clk), .rst(rst), .instr(instr), .onzc(onzc), .mem(bus),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_source_a(alu_source_a), .alu_source_b(alu_source_b),
    .alu_control(alu_control), .result_source(result_source),
    .immediate_source(immediate_source), .illegal(illegal),
    .bus_error(bus_error), .state(dstate)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  exp_t q[$];
  exp_t act, expv;
  logic ill_f = 0;
  logic berr_f = 0;
  logic [31:0] ins_v = 0;

  always @(negedge clk) begin
    if (q.size() != 0) begin
      expv = q.pop_front();
      act.st = dstate;
      act.mreq = bus.mem_request;
      act.adr = bus.adr_source;
      act.irw = ir_write;
      act.pcw = pc_write;
      act.mw = bus.memory_write;
      act.rw = reg_write;
      act.sa = alu_source_a;
      act.sb = alu_source_b;
      act.alu = alu_control;
      act.rs = result_source;
      act.imm = immediate_source;
      act.ill = illegal;
      act.berr = bus_error;
      tests++;
      if (act !== expv) begin
        fails++;
        $display("FAIL cycle@%0t instr=%h actual=%h required=%h",
                 $time, instr, act, expv);
      end
    end
  end

  function automatic exp_t mk(input logic [3:0] s);
    exp_t e;
    e = '0;
    e.st = s;
    e.ill = ill_f;
    e.berr = berr_f;
    return e;
  endfunction

  task automatic cyc(input exp_t e, input logic rdy, input logic r,
                     input logic [3:0] f);
    @(posedge clk);
    #1;
    rst = r;
    instr = ins_v;
    bus.mem_ready = rdy;
    onzc = f;
    q.push_back(e);
  endtask

  task automatic cy(input exp_t e);
    cyc(e, 1'($urandom), 1'b0, 4'($urandom));
  endtask

  task automatic wait_ph(input exp_t base, input exp_t done, input int w,
                         output bit to);
    to = 0;
    for (int i = 0; i < w && i < MW; i++)
      cyc(base, 1'b0, 1'b0, 4'($urandom));
    if (w >= MW) begin
      to = 1;
      berr_f = 1;
    end else begin
      cyc(done, 1'b1, 1'b0, 4'($urandom));
    end
  endtask

  task automatic trap(input int n);
    for (int i = 0; i < n; i++) cy(mk(S_TRAP));
    cyc(mk(S_TRAP), 1'($urandom), 1'b1, 4'($urandom));
    ill_f = 0;
    berr_f = 0;
  endtask

  function automatic logic [3:0] alu_of(input logic [2:0] f3,
                                        input logic f7, input bit isr);
    case (f3)
      3'd0: return (isr && f7) ? 4'd1 : 4'd0;
      3'd1: return 4'd5;
      3'd2: return 4'd8;
      3'd3: return 4'd9;
      3'd4: return 4'd4;
      3'd5: return f7 ? 4'd7 : 4'd6;
      3'd6: return 4'd3;
      default: return 4'd2;
    endcase
  endfunction

  task automatic fetch(input int fw, output bit to);
    exp_t e, d;
    e = mk(S_FETCH);
    e.mreq = 1; e.sb = 2; e.rs = 2;
    d = e; d.irw = 1; d.pcw = 1;
    wait_ph(e, d, fw, to);
  endtask

  task automatic run(input logic [31:0] ins, input int fw, input int dw,
                     input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit to;
    logic [31:0] diff;
    logic [3:0] f;
    logic tk;
    ins_v = ins;
    fetch(fw, to);
    if (to) begin trap(3); return; end
    e = mk(S_DECODE);
    e.sa = 1; e.sb = 1; e.imm = 2;
    cy(e);
    case (ins[6:0])
      7'h03, 7'h23: begin
        e = mk(S_MEM_ADR);
        e.sa = 2; e.sb = 1; e.imm = (ins[6:0] == 7'h23) ? 3'd1 : 3'd0;
        cy(e);
        if (ins[6:0] == 7'h23) begin
          e = mk(S_MEM_WRITE);
          e.mreq = 1; e.adr = 1; e.mw = 1;
          wait_ph(e, e, dw, to);
        end else begin
          e = mk(S_MEM_READ);
          e.mreq = 1; e.adr = 1;
          wait_ph(e, e, dw, to);
          if (!to) begin
            e = mk(S_MEM_WB); e.rs = 1; e.rw = 1; cy(e);
          end
        end
        if (to) trap(3);
      end
      7'h33, 7'h13: begin
        e = mk(ins[4] && !ins[5] ? S_EXEC_I : S_EXEC_R);
        e.sa = 2;
        e.sb = (ins[6:0] == 7'h13) ? 2'd1 : 2'd0;
        e.alu = alu_of(ins[14:12], ins[30], ins[6:0] == 7'h33);
        cy(e);
        e = mk(S_ALU_WB); e.rw = 1; cy(e);
      end
      7'h63: begin
        diff = a - b;
        f[3] = (a[31] != b[31]) && (diff[31] != a[31]);
        f[2] = diff[31];
        f[1] = (diff == 0);
        f[0] = (a >= b);
        case (ins[14:12])
          3'd0: tk = (a == b);
          3'd1: tk = (a != b);
          3'd4: tk = ($signed(a) < $signed(b));
          3'd5: tk = ($signed(a) >= $signed(b));
          3'd6: tk = (a < b);
          3'd7: tk = (a >= b);
          default: tk = 0;
        endcase
        e = mk(S_BRANCH);
        e.sa = 2; e.alu = 1; e.pcw = tk;
        cyc(e, 1'($urandom), 1'b0, f);
        if (ins[14:12] == 3'd2 || ins[14:12] == 3'd3) begin
          ill_f = 1;
          trap(3);
        end
      end
      7'h6F: begin
        e = mk(S_JAL); e.sa = 1; e.sb = 2; e.pcw = 1; cy(e);
        e = mk(S_ALU_WB); e.rw = 1; cy(e);
      end
      7'h67: begin
        e = mk(S_JALR); e.sa = 2; e.sb = 1; cy(e);
        e = mk(S_JALR_LINK); e.sa = 1; e.sb = 2; e.pcw = 1; cy(e);
        e = mk(S_ALU_WB); e.rw = 1; cy(e);
      end
      7'h37: begin
        e = mk(S_LUI); e.sa = 3; e.sb = 1; e.imm = 4; cy(e);
        e = mk(S_ALU_WB); e.rw = 1; cy(e);
      end
      default: begin
        ill_f = 1;
        trap(10);
      end
    endcase
  endtask

  task automatic rst_in_store();
    exp_t e;
    bit to;
    ins_v = 32'h0020A223;
    fetch(0, to);
    e = mk(S_DECODE); e.sa = 1; e.sb = 1; e.imm = 2; cy(e);
    e = mk(S_MEM_ADR); e.sa = 2; e.sb = 1; e.imm = 1; cy(e);
    e = mk(S_MEM_WRITE); e.mreq = 1; e.adr = 1; e.mw = 1;
    cyc(e, 1'b0, 1'b0, 4'd0);
    cyc(mk(S_MEM_WRITE), 1'b0, 1'b1, 4'd0);
  endtask

  logic [6:0] legal_ops [8] = '{7'h03, 7'h23, 7'h33, 7'h13,
                                7'h63, 7'h6F, 7'h67, 7'h37};
  logic [6:0] bad_ops [5] = '{7'h7F, 7'h0F, 7'h73, 7'h17, 7'h00};

  initial begin
    logic [31:0] ri;
    int fw, dw;
    bus.mem_ready = 0;
    @(posedge clk);
    cyc(mk(S_FETCH), 1'b0, 1'b1, 4'd0);
    run(32'h002081B3, 0, 0, 0, 0);
    run(32'h0080A283, 0, 3, 0, 0);
    run(32'h00208063, 0, 0, 32'd7, 32'd7);
    run(32'h00208063, 0, 0, 32'd7, 32'd9);
    run(32'h0020C063, 0, 0, 32'h80000000, 32'd1);
    run(32'h000080E7, 0, 0, 0, 0);
    run(32'h0020A223, 2, 3, 0, 0);
    run(32'h0000007F, 0, 0, 0, 0);
    run(32'h002081B3, MW, 0, 0, 0);
    run(32'h0080A283, 0, MW, 0, 0);
    rst_in_store();
    run(32'h40208133, 1, 0, 0, 0);
    for (int n = 0; n < 150; n++) begin
      ri = $urandom;
      if ($urandom_range(0, 9) == 0)
        ri[6:0] = bad_ops[$urandom_range(0, 4)];
      else
        ri[6:0] = legal_ops[$urandom_range(0, 7)];
      fw = ($urandom_range(0, 19) == 0) ? MW : $urandom_range(0, 3);
      dw = ($urandom_range(0, 19) == 0) ? MW : $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0)
        run(ri, fw, dw, $urandom, $urandom);
      else
        run(ri, fw, dw, $urandom_range(0, 3), $urandom_range(0, 3));
    end
    repeat (3) @(posedge clk);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain left=%0d required=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
